serial_frame_deserializer: RTL and testbench

Downstream consumer of the serial-serial shift register stage. It watches the register's single-bit serial output, detects framed words (start bit, WIDTH data bits, stop bit), assembles each word in parallel, and presents it to the next stage through a valid/ready holding buffer. Bit order follows the same left/right (leri) convention used by the shift register, so a word shifted in either direction is rebuilt correctly.

---
 rtl/serial_frame_deserializer.sv | 103 ++++++++++
 tb/tb_serial_frame_deserializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//   Watches a single-bit serial line for framed words (start=1, WIDTH data
//   bits, stop=0). It assembles each word in the bit order selected by leri,
//   which is captured at the start bit. Good words are offered through a
//   one-entry valid/ready holding buffer.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   ena            clock enable; when low, all state holds
//   in             serial data, idle level 0
//   leri           1 = MSB first, 0 = LSB first (sampled at the start bit)
//   out_data       assembled word, held while out_valid
//   out_valid      out_data holds an unconsumed word
//   out_ready      consumer accepts on out_valid && out_ready (only when ena)
//   frame_err      one-cycle pulse after a stop bit sampled as 1
//   overrun        sticky until rst: a good word was dropped, buffer full
//   busy           frame in progress (state != IDLE)
module serial_frame_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in,
    input  logic             leri,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic             frame_dir;

    // Good frame completes on this cycle's STOP sample.
    logic good;
    assign good = ena && (state == STOP) && !in;

    // state is a register, so busy has no combinational path from inputs.
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            frame_dir <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (in) begin
                            frame_dir <= leri;
                            cnt       <= '0;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        // First received bit ends up at MSB (dir 1) or LSB (dir 0).
                        if (frame_dir) acc <= {acc[WIDTH-2:0], in};
                        else           acc <= {in, acc[WIDTH-1:1]};
                        if (cnt == CW'(WIDTH - 1)) state <= STOP;
                        else                       cnt   <= cnt + 1'b1;
                    end
                    STOP: begin
                        // No start detection here; the next start is sampled in IDLE.
                        state <= IDLE;
                        if (in) frame_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase

                // A commit and a consume on the same edge swap the word in place.
                if (good) begin
                    if (!out_valid || out_ready) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
module tb_serial_frame_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             in = 1'b0;
    logic             leri = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    serial_frame_deserializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in(in), .leri(leri),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Buffer-level reference: what the consumer should see.
    bit               mv;
    logic [WIDTH-1:0] md;
    bit               mo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs settle and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_buf(input string tag);
        chk({tag, "_valid"}, out_valid, mv);
        if (mv) chk({tag, "_data"}, out_data, md);
        chk({tag, "_overrun"}, overrun, mo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        #1;
        rst = 1'b0;
        mv = 0; md = '0; mo = 0;
    endtask

    // stream[i] is the i-th data bit on the wire; expw is the word it should form.
    task automatic drive_frame(input bit dir, input logic [WIDTH-1:0] stream, input bit stp,
                               input int st_at, input int st_len, input bit rdy,
                               input logic [WIDTH-1:0] expw);
        ena = 1; out_ready = 0; in = 1; leri = dir;
        tick();
        chk("busy_start", busy, 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == st_at) begin
                for (int j = 0; j < st_len; j++) begin
                    ena = 0; in = 1'($urandom); out_ready = 1; leri = 1'($urandom);
                    tick();
                end
            end
            ena = 1; out_ready = 0; in = stream[i]; leri = 1'($urandom);
            tick();
        end
        chk("valid_pre_stop", out_valid, mv);
        chk("busy_pre_stop", busy, 1);
        in = stp; out_ready = rdy;
        tick();
        in = 0; out_ready = 0;
        if (!stp) begin
            if (!mv || rdy) begin mv = 1; md = expw; end
            else mo = 1;
        end else if (mv && rdy) begin
            mv = 0;
        end
        chk("ferr_pulse", frame_err, stp);
        chk("busy_end", busy, 0);
        check_buf("commit");
        tick();
        chk("ferr_clear", frame_err, 0);
    endtask

    function automatic logic [WIDTH-1:0] stream_of(input logic [WIDTH-1:0] w, input bit dir);
        logic [WIDTH-1:0] s;
        for (int i = 0; i < WIDTH; i++) s[i] = dir ? w[WIDTH-1-i] : w[i];
        return s;
    endfunction

    task automatic idle_cycle(input bit e, input bit rdy);
        ena = e; in = e ? 1'b0 : 1'($urandom); out_ready = rdy;
        tick();
        if (e && rdy && mv) mv = 0;
        ena = 1; in = 0; out_ready = 0;
        check_buf("idle");
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        bit dir;
        mv = 0; md = '0; mo = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Quiet line after reset.
        ena = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data", out_data, 0);
        chk("idle_overrun", overrun, 0);

        // Directed streams, expected words written out by hand.
        drive_frame(1, 8'hA5, 0, WIDTH, 0, 0, 8'hA5);
        idle_cycle(1, 1);
        chk("consume_valid", out_valid, 0);
        drive_frame(0, 8'hA5, 0, WIDTH, 0, 0, 8'hA5);
        idle_cycle(1, 1);
        drive_frame(0, 8'h01, 0, WIDTH, 0, 0, 8'h01);
        idle_cycle(1, 1);
        drive_frame(1, 8'h01, 0, WIDTH, 0, 0, 8'h80);

        // Bad stop leaves the held word alone.
        drive_frame(1, 8'hFF, 1, WIDTH, 0, 0, 8'hFF);
        chk("badstop_data", out_data, 8'h80);

        // Overrun, then a consume on the commit edge.
        do_reset();
        drive_frame(1, 8'h3C, 0, WIDTH, 0, 0, 8'h3C);
        drive_frame(1, 8'hC3, 0, WIDTH, 0, 0, 8'hC3);
        chk("ovr_data", out_data, 8'h3C);
        chk("ovr_flag", overrun, 1);
        do_reset();
        drive_frame(1, 8'h3C, 0, WIDTH, 0, 0, 8'h3C);
        drive_frame(1, 8'hC3, 0, WIDTH, 0, 1, 8'hC3);
        chk("swap_data", out_data, 8'hC3);
        chk("swap_valid", out_valid, 1);
        chk("swap_overrun", overrun, 0);

        // Enable stall inside the data bits.
        idle_cycle(1, 1);
        drive_frame(1, stream_of(8'h5A, 1), 0, 3, 3, 0, 8'h5A);
        chk("stall_data", out_data, 8'h5A);

        // Mid-frame reset after 4 data bits.
        ena = 1; in = 1; leri = 1;
        tick();
        for (int i = 0; i < 4; i++) begin in = 1'($urandom); tick(); end
        rst = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        #1;
        rst = 0;
        mv = 0; md = '0; mo = 0;
        in = 0;
        for (int i = 0; i < WIDTH + 3; i++) tick();
        chk("midrst_after_valid", out_valid, 0);
        chk("midrst_after_busy", busy, 0);

        // Randomized traffic against the buffer model.
        for (int n = 0; n < 60; n++) begin
            w = WIDTH'($urandom);
            dir = 1'($urandom);
            drive_frame(dir, stream_of(w, dir), ($urandom_range(0, 7) == 0),
                        $urandom_range(0, WIDTH - 1), $urandom_range(0, 3),
                        1'($urandom), w);
            for (int g = $urandom_range(0, 3); g > 0; g--)
                idle_cycle($urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
